// File: rtl/one_to_n_distributor.sv
// one_to_n_distributor
// Accepts one flit stream through a 2-entry input queue and steers each packet
// to one of N output ports. The head/single flit's destination field selects the
// port; body and tail flits follow the locked port (wormhole). Unroutable,
// orphan or out-of-protocol flits raise a registered err pulse and a saturating
// error count.
module one_to_n_distributor #(
   parameter int                    FLIT_SIZE  = 34,
   parameter int                    HEADER_LEN = 2,
   parameter int                    N          = 3,
   parameter int                    DEST_POS   = FLIT_SIZE - HEADER_LEN - 1,
   parameter int                    DEST_LEN   = 2,
   parameter int                    ERR_W      = 16,
   // Flit type codes; anything that is not HEAD, TAIL or SINGLE is a BODY flit
   parameter logic [HEADER_LEN-1:0] TYPE_HEAD   = 2'b10,
   parameter logic [HEADER_LEN-1:0] TYPE_TAIL   = 2'b01,
   parameter logic [HEADER_LEN-1:0] TYPE_SINGLE = 2'b11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FLIT_SIZE-1:0]   in,
   input  logic                   in_valid,
   output logic                   in_avail,
   output logic [FLIT_SIZE*N-1:0] out,
   output logic [N-1:0]           out_valid,
   input  logic [N-1:0]           out_avail,
   output logic                   busy,
   output logic                   err,
   output logic [ERR_W-1:0]       err_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

   localparam logic [31:0] N_U = 32'(N);

   state_t                r_state;
   state_t                w_next_state;
   logic [FLIT_SIZE-1:0]  r_mem [2];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;
   logic [DEST_LEN-1:0]   r_route;
   logic                  r_err;
   logic [ERR_W-1:0]      r_err_cnt;

   logic                  w_full;
   logic                  w_head_valid;
   logic                  w_wr;
   logic                  w_consume;
   logic [FLIT_SIZE-1:0]  w_head;
   logic [HEADER_LEN-1:0] w_type;
   logic [DEST_LEN-1:0]   w_dest;
   logic                  w_dest_ok;
   logic                  w_is_head;
   logic                  w_is_single;
   logic                  w_is_tail;
   logic                  w_fwd;
   logic                  w_err_evt;
   logic [DEST_LEN-1:0]   w_tgt;
   logic                  w_tgt_avail;

   // Input queue status and head-flit decode
   assign w_full       = (r_count == 2'd2);
   assign w_head_valid = (r_count != 2'd0);
   assign w_wr         = in_valid & ~w_full;   // a write while full is dropped even if a read frees a slot
   assign w_head       = r_mem[r_rd_ptr];
   assign w_type       = w_head[FLIT_SIZE-1 -: HEADER_LEN];
   assign w_dest       = w_head[DEST_POS -: DEST_LEN];
   assign w_dest_ok    = (32'(w_dest) < N_U);
   assign w_is_head    = (w_type == TYPE_HEAD);
   assign w_is_single  = (w_type == TYPE_SINGLE);
   assign w_is_tail    = (w_type == TYPE_TAIL);

   // Queue storage: data only, qualified by the count
   // NOTE: the payload array has no reset; r_count marks which entries are live,
   // so clearing the data would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= in;
   end

   // Queue pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_wr)      r_wr_ptr <= ~r_wr_ptr;
         if (w_consume) r_rd_ptr <= ~r_rd_ptr;
         case ({w_wr, w_consume})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FSM state register
   // NOTE: every clocked register uses <= so all flops sample pre-edge values
   // regardless of the order the always_ff blocks are evaluated in.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // FSM next state: transitions happen only on the cycle the head is consumed
   always_comb begin
      w_next_state = r_state;
      if (w_consume) begin
         case (r_state)
            S_IDLE:  if (w_is_head) w_next_state = w_dest_ok ? S_FWD : S_DROP;
            S_FWD:   if (w_is_tail) w_next_state = S_IDLE;
            S_DROP:  if (w_is_tail) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // FSM outputs: target port, forward/drop decision, consume strobe and per-port valid
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_fwd       = 1'b0;
      w_err_evt   = 1'b0;
      w_tgt       = r_route;
      w_tgt_avail = 1'b0;
      out_valid   = '0;
      case (r_state)
         S_IDLE: begin
            w_tgt = w_dest;
            if ((w_is_head || w_is_single) && w_dest_ok) w_fwd     = 1'b1;
            else                                         w_err_evt = 1'b1;
         end
         S_FWD: begin
            w_fwd     = 1'b1;
            w_err_evt = w_is_head || w_is_single;   // protocol violation, lock kept
         end
         S_DROP: begin
            w_err_evt = w_is_head || w_is_single;
         end
         default: ;
      endcase
      for (int k = 0; k < N; k++) begin
         if (w_tgt == DEST_LEN'(k)) w_tgt_avail = out_avail[k];
         out_valid[k] = w_head_valid && w_fwd && (w_tgt == DEST_LEN'(k)) && out_avail[k];
      end
      // Dropped flits do not wait for any downstream port
      w_consume = w_head_valid && (w_fwd ? w_tgt_avail : 1'b1);
   end

   // Lock the route when a routable HEAD opens a packet
   always_ff @(posedge clk) begin
      if (rst)
         r_route <= '0;
      else if (w_consume && (r_state == S_IDLE) && w_is_head && w_dest_ok)
         r_route <= w_dest;
   end

   // Registered error pulse and saturating error counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err <= w_consume && w_err_evt;
         if (w_consume && w_err_evt && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign in_avail = ~w_full;
   assign out      = {N{w_head}};
   assign busy     = (r_state != S_IDLE);
   assign err      = r_err;
   assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_one_to_n_distributor.sv
// Self-checking bench for one_to_n_distributor (N=3, DEST_LEN=2, ERR_W=16).
// Expected output flits are queued with their port when driven and compared
// when the DUT presents them; error pulses and err_cnt follow a small model.
`timescale 1ns/1ps
module tb_one_to_n_distributor;

   localparam int FW = 34;
   localparam int HL = 2;
   localparam int N  = 3;
   localparam int DL = 2;
   localparam int EW = 16;
   localparam int DP = FW - HL - 1;

   localparam logic [1:0] T_HEAD   = 2'b10;
   localparam logic [1:0] T_BODY   = 2'b00;
   localparam logic [1:0] T_TAIL   = 2'b01;
   localparam logic [1:0] T_SINGLE = 2'b11;

   logic            clk = 1'b0;
   logic            rst;
   logic [FW-1:0]   tb_in;
   logic            tb_in_valid;
   logic            tb_in_avail;
   logic [FW*N-1:0] tb_out;
   logic [N-1:0]    tb_out_valid;
   logic [N-1:0]    tb_out_avail;
   logic            tb_busy;
   logic            tb_err;
   logic [EW-1:0]   tb_err_cnt;

   typedef struct {
      int            port;
      logic [FW-1:0] flit;
   } sb_t;

   sb_t sb[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  err_seen = 0;
   int  err_exp  = 0;
   int  cnt_exp  = 0;

   logic [2:0] s2_ov [6];
   logic       s2_bz [6];
   logic [2:0] s2_ov_exp [6] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
   logic       s2_bz_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

   one_to_n_distributor #(
      .FLIT_SIZE(FW), .HEADER_LEN(HL), .N(N), .DEST_POS(DP), .DEST_LEN(DL), .ERR_W(EW),
      .TYPE_HEAD(T_HEAD), .TYPE_TAIL(T_TAIL), .TYPE_SINGLE(T_SINGLE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in(tb_in),
      .in_valid(tb_in_valid),
      .in_avail(tb_in_avail),
      .out(tb_out),
      .out_valid(tb_out_valid),
      .out_avail(tb_out_avail),
      .busy(tb_busy),
      .err(tb_err),
      .err_cnt(tb_err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] d, input logic [15:0] p);
      logic [FW-1:0] f;
      f = '0;
      f[FW-1 -: 2] = t;
      f[DP -: 2]   = d;
      f[15:0]      = p;
      return f;
   endfunction

   // Output monitor: every forwarded flit must match the oldest expected entry
   always @(negedge clk) begin
      sb_t e;
      if (tb_err === 1'b1) err_seen++;
      if (tb_out_valid !== '0) begin
         check("out_onehot", 64'($countones(tb_out_valid)), 64'd1);
         if (sb.size() == 0) begin
            check("unexpected_out", 64'(tb_out_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            check("out_port", 64'(tb_out_valid), 64'(1 << e.port));
            check("out_flit", 64'(tb_out[e.port*FW +: FW]), 64'(e.flit));
         end
      end
   end

   // Write one flit; called #1 after a rising edge, returns #1 after the accepting edge
   task automatic push_flit(input logic [FW-1:0] f);
      int   guard;
      logic acc;
      guard = 0;
      tb_in       = f;
      tb_in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = tb_in_avail;
         @(posedge clk);
         #1;
         guard++;
      end while (!acc && guard < 50);
      if (!acc) check("push_timeout", 64'(acc), 64'd1);
      tb_in_valid = 1'b0;
   endtask

   // port < 0 means the flit must be dropped; n_err is the number of err pulses it causes
   task automatic send(input logic [1:0] t, input logic [1:0] d, input logic [15:0] p,
                       input int port, input int n_err);
      sb_t e;
      e.flit = mk(t, d, p);
      e.port = port;
      if (port >= 0) sb.push_back(e);
      for (int i = 0; i < n_err; i++) begin
         err_exp++;
         if (cnt_exp < 65535) cnt_exp++;
      end
      push_flit(e.flit);
   endtask

   task automatic drain_and_check(input string tag);
      repeat (6) @(posedge clk);
      #1;
      check({tag, "_err_pulses"}, 64'(err_seen), 64'(err_exp));
      check({tag, "_err_cnt"}, 64'(tb_err_cnt), 64'(cnt_exp));
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
      check({tag, "_idle"}, 64'(tb_busy), 64'd0);
   endtask

   initial begin
      rst          = 1'b1;
      tb_in        = '0;
      tb_in_valid  = 1'b0;
      tb_out_avail = 3'b111;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_in_avail", 64'(tb_in_avail), 64'd1);
      check("rst_out_valid", 64'(tb_out_valid), 64'd0);
      check("rst_busy", 64'(tb_busy), 64'd0);
      check("rst_err", 64'(tb_err), 64'd0);
      check("rst_err_cnt", 64'(tb_err_cnt), 64'd0);
      @(posedge clk);
      #1;

      // 1: SINGLE dest=2, payload 0xA5, visible the cycle after the write
      send(T_SINGLE, 2'd2, 16'h00A5, 2, 0);
      @(negedge clk);
      check("s1_out_valid", 64'(tb_out_valid), 64'b100);
      check("s1_payload", 64'(tb_out[2*FW +: 8]), 64'hA5);
      check("s1_busy", 64'(tb_busy), 64'd0);
      check("s1_err", 64'(tb_err), 64'd0);
      drain_and_check("s1");

      // 2: 4-flit packet to port 1, body carries dest bits 2 which must be ignored
      @(posedge clk);
      #1;
      fork
         begin
            send(T_HEAD, 2'd1, 16'h1001, 1, 0);
            send(T_BODY, 2'd2, 16'h1002, 1, 0);
            send(T_BODY, 2'd0, 16'h1003, 1, 0);
            send(T_TAIL, 2'd3, 16'h1004, 1, 0);
         end
         begin
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               s2_ov[i] = tb_out_valid;
               s2_bz[i] = tb_busy;
            end
         end
      join
      for (int i = 0; i < 6; i++) begin
         check($sformatf("s2_out_valid_c%0d", i), 64'(s2_ov[i]), 64'(s2_ov_exp[i]));
         check($sformatf("s2_busy_c%0d", i), 64'(s2_bz[i]), 64'(s2_bz_exp[i]));
      end
      drain_and_check("s2");

      // 3: backpressure on port 0 for 3 cycles mid-packet
      @(posedge clk);
      #1;
      fork
         begin
            send(T_HEAD, 2'd0, 16'h3001, 0, 0);
            send(T_BODY, 2'd0, 16'h3002, 0, 0);
            send(T_BODY, 2'd1, 16'h3003, 0, 0);
            send(T_BODY, 2'd2, 16'h3004, 0, 0);
            send(T_TAIL, 2'd0, 16'h3005, 0, 0);
         end
         begin
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            tb_out_avail = 3'b110;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check($sformatf("s3_stall_out_valid_c%0d", i), 64'(tb_out_valid), 64'd0);
               check($sformatf("s3_stall_in_avail_c%0d", i), 64'(tb_in_avail), 64'(i == 0));
               @(posedge clk);
               #1;
            end
            tb_out_avail = 3'b111;
         end
      join
      drain_and_check("s3");

      // 4: unroutable packet dropped with a single err, then a SINGLE to port 0
      @(posedge clk);
      #1;
      send(T_HEAD, 2'd3, 16'h4001, -1, 1);
      send(T_BODY, 2'd0, 16'h4002, -1, 0);
      send(T_TAIL, 2'd0, 16'h4003, -1, 0);
      send(T_SINGLE, 2'd0, 16'h4004, 0, 0);
      drain_and_check("s4");
      check("s4_err_cnt_is_1", 64'(tb_err_cnt), 64'd1);

      // 5: orphan TAIL, then enough errors to saturate the counter
      @(posedge clk);
      #1;
      send(T_TAIL, 2'd1, 16'h5001, -1, 1);
      drain_and_check("s5a");
      check("s5_err_cnt_is_2", 64'(tb_err_cnt), 64'd2);
      @(posedge clk);
      #1;
      for (int i = 0; i < 65536; i++)
         send(T_TAIL, 2'($urandom_range(3)), 16'($urandom), -1, 1);
      drain_and_check("s5b");
      check("s5_err_cnt_sat", 64'(tb_err_cnt), 64'hFFFF);

      // 6: reset mid-packet discards the queued body and the lock
      @(posedge clk);
      #1;
      send(T_HEAD, 2'd2, 16'h6001, 2, 0);
      @(posedge clk);
      #1;
      tb_out_avail = 3'b011;
      send(T_BODY, 2'd0, 16'h6002, -1, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      tb_out_avail = 3'b111;
      cnt_exp      = 0;
      @(negedge clk);
      check("s6_in_avail", 64'(tb_in_avail), 64'd1);
      check("s6_out_valid", 64'(tb_out_valid), 64'd0);
      check("s6_busy", 64'(tb_busy), 64'd0);
      check("s6_err_cnt", 64'(tb_err_cnt), 64'd0);
      @(posedge clk);
      #1;
      send(T_SINGLE, 2'd1, 16'h6003, 1, 0);
      drain_and_check("s6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
